// File: rtl/mem_bus_ram_if.sv
// mem_bus: single-request memory bus between the core master and a memory slave.
//   master drives addr/be/wr_en/wr_data/rd_en; slave returns rd_data/busy/ack.
interface mem_bus;
  logic [31:0] addr;
  logic [3:0]  be;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        busy;
  logic        ack;

  modport master (output addr, be, wr_en, wr_data, rd_en,
                  input  rd_data, busy, ack);
  modport slave  (input  addr, be, wr_en, wr_data, rd_en,
                  output rd_data, busy, ack);
endinterface

// File: rtl/mem_bus_ram.sv
// mem_bus_ram: word-organised on-chip RAM on the slave side of mem_bus.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (FSM/outputs only, array untouched)
//   bus   : mem_bus.slave -- addr/be/wr_en/wr_data/rd_en in, rd_data/busy/ack out
// A request is accepted in IDLE or ACK, waits WAIT_STATES cycles with busy=1,
// then commits on the edge entering ACK, where ack is high for one cycle.
module mem_bus_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic   clk,
  input  logic   reset,
  mem_bus.slave  bus
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;
  localparam logic [2:0] WS_M1 = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  typedef struct packed {
    logic [AW-1:0]                idx;
    logic [NUM_LANES-1:0]         be;
    logic                         wr;
    logic [NUM_LANES-1:0][7:0]    data;
  } req_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d, in_req, cm_req;
  logic [31:0] rd_data_q;
  logic        accept, commit;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH_WORDS];

  // Address bits outside the word index are don't-care (addresses wrap).
  logic unused_addr;
  assign unused_addr = ^{bus.addr[1:0], bus.addr[31:AW+2]};

  always_comb begin
    in_req.idx  = bus.addr[AW+1:2];
    in_req.be   = bus.be;
    in_req.wr   = bus.wr_en;   // rd_en & wr_en together counts as a write
    in_req.data = bus.wr_data;
    accept  = (state_q != WAIT) && (bus.rd_en || bus.wr_en);
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cm_req  = req_q;
    case (state_q)
      IDLE, ACK: begin
        if (accept) begin
          req_d  = in_req;
          // With zero wait states the commit edge is the accept edge, so the
          // live request is what gets committed.
          cm_req = in_req;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_M1;
          end else begin
            state_d = ACK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = ACK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    commit = (state_d == ACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      req_q     <= '0;
      rd_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (commit && !cm_req.wr) rd_data_q <= mem[cm_req.idx];
    end
  end

  // Array has no reset; a pending write is dropped because reset forces the
  // FSM out of WAIT before it can reach the commit edge.
  always_ff @(posedge clk) begin
    if (commit && cm_req.wr) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (cm_req.be[i]) mem[cm_req.idx][i] <= cm_req.data[i];
    end
  end

  assign bus.busy    = (state_q == WAIT);
  assign bus.ack     = (state_q == ACK);
  assign bus.rd_data = rd_data_q;
endmodule
